// File: rtl/my_node_info.sv
// Per-node routing/energy state: latches hop distance, normalized-energy Q-value,
// cluster-head role and low-energy flag from decoded packets strobed by en_MNI.
module my_node_info #(
   parameter logic [15:0] NODE_ID = 16'h000C
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        en_MNI,
   input  logic [2:0]  fPktType,
   input  logic [15:0] e_max,
   input  logic [15:0] e_min,
   input  logic [15:0] energy,
   input  logic [15:0] destinationID,
   input  logic [15:0] hops,
   input  logic [15:0] timeslot,
   input  logic [15:0] e_threshold,
   output logic [15:0] myNodeID,
   output logic [15:0] hopsFromSink,
   output logic [15:0] myQValue,
   output logic        role,
   output logic        low_E
);

   typedef enum logic [2:0] {
      PKT_HB   = 3'b000,
      PKT_CHE  = 3'b001,
      PKT_INV  = 3'b010,
      PKT_CHT  = 3'b100,
      PKT_DATA = 3'b101
   } pkt_t;

   pkt_t        pkt_type;
   logic        hb_lock;
   logic [15:0] e_diff;
   logic [15:0] e_span;
   logic [29:0] q_num;
   logic [29:0] q_quo;
   logic [15:0] e_norm;
   logic        unused_bits;

   assign pkt_type = pkt_t'(fPktType);
   assign myNodeID = NODE_ID;

   // Saturation cases are decided before the divide so the quotient only ever
   // sees energy strictly between e_min and e_max, keeping it within 15 bits.
   always_comb begin
      e_diff = energy - e_min;
      e_span = e_max - e_min;
      q_num  = {e_diff, 14'b0};
      q_quo  = '0;
      e_norm = '0;
      if (energy <= e_min) begin
         e_norm = '0;
      end else if ((energy >= e_max) || (e_max <= e_min)) begin
         e_norm = 16'h4000;
      end else begin
         q_quo  = q_num / {14'b0, e_span};
         e_norm = q_quo[15:0];
      end
   end

   assign unused_bits = ^{timeslot, q_quo[29:16]};

   always_ff @(posedge clk) begin
      if (!nrst) begin
         hopsFromSink <= '0;
         myQValue     <= '0;
         role         <= 1'b0;
         low_E        <= 1'b0;
         hb_lock      <= 1'b0;
      end else if (en_MNI) begin
         low_E <= (energy <= e_threshold);
         case (pkt_type)
            PKT_HB: begin
               if (!hb_lock) begin
                  hopsFromSink <= hops;
                  myQValue     <= e_norm;
                  role         <= 1'b0;
                  hb_lock      <= 1'b1;
               end
            end
            PKT_CHE: begin
               if (destinationID == NODE_ID) role <= 1'b1;
            end
            PKT_DATA: hb_lock <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_my_node_info.sv
// Scoreboard bench for my_node_info: directed packets push hand-computed
// expectations; a monitor compares them one cycle after each strobe or reset edge.
module tb_my_node_info;

   logic        clk;
   logic        nrst;
   logic        en_MNI;
   logic [2:0]  fPktType;
   logic [15:0] e_max, e_min, energy, destinationID, hops, timeslot, e_threshold;
   logic [15:0] myNodeID, hopsFromSink, myQValue;
   logic        role, low_E;

   typedef struct {
      logic [15:0] hops;
      logic [15:0] q;
      logic        role;
      logic        low;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   my_node_info #(.NODE_ID(16'h000C)) dut (
      .clk(clk), .nrst(nrst), .en_MNI(en_MNI), .fPktType(fPktType),
      .e_max(e_max), .e_min(e_min), .energy(energy),
      .destinationID(destinationID), .hops(hops), .timeslot(timeslot),
      .e_threshold(e_threshold), .myNodeID(myNodeID),
      .hopsFromSink(hopsFromSink), .myQValue(myQValue),
      .role(role), .low_E(low_E)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every edge that samples a strobe or reset produces one response.
   always @(posedge clk) begin
      if (en_MNI || !nrst) begin
         #1;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow actual=empty required=entry at %0t", $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("myNodeID",     myNodeID,       16'h000C);
            chk("hopsFromSink", hopsFromSink,   e.hops);
            chk("myQValue",     myQValue,       e.q);
            chk("role",         {15'b0, role},  {15'b0, e.role});
            chk("low_E",        {15'b0, low_E}, {15'b0, e.low});
         end
      end
   end

   task automatic push(input logic [15:0] h, input logic [15:0] q, input logic r, input logic l);
      exp_t e;
      e.hops = h; e.q = q; e.role = r; e.low = l;
      exp_q.push_back(e);
   endtask

   task automatic pkt(input logic [2:0] t, input logic [15:0] h, input logic [15:0] emx,
                      input logic [15:0] emn, input logic [15:0] en, input logic [15:0] dst,
                      input logic [15:0] xh, input logic [15:0] xq, input logic xr, input logic xl);
      @(negedge clk);
      en_MNI = 1'b1; fPktType = t; hops = h; e_max = emx; e_min = emn;
      energy = en; destinationID = dst;
      push(xh, xq, xr, xl);
   endtask

   task automatic idle();
      @(negedge clk);
      en_MNI = 1'b0;
   endtask

   initial begin
      nrst = 1'b0; en_MNI = 1'b0; fPktType = '0; e_max = '0; e_min = '0;
      energy = '0; destinationID = '0; hops = '0; timeslot = 16'h00A5;
      e_threshold = 16'h3333;

      for (int i = 0; i < 5; i++) begin
         push(16'h0, 16'h0, 1'b0, 1'b0);
         @(negedge clk);
      end
      nrst = 1'b1;
      idle();

      //    type    hops   e_max    e_min    energy   dest     hops  Q        role  low
      pkt(3'b000, 16'd1, 16'h8000, 16'h4000, 16'h8000, 16'd0,  16'd1, 16'h4000, 1'b0, 1'b0);
      pkt(3'b000, 16'd2, 16'h8000, 16'h4000, 16'h7FC0, 16'd0,  16'd1, 16'h4000, 1'b0, 1'b0);
      pkt(3'b000, 16'd2, 16'h8000, 16'h4000, 16'h3000, 16'd0,  16'd1, 16'h4000, 1'b0, 1'b1);
      idle();
      pkt(3'b001, 16'd0, 16'h8000, 16'h4000, 16'h8000, 16'd32, 16'd1, 16'h4000, 1'b0, 1'b0);
      pkt(3'b010, 16'd0, 16'h8000, 16'h4000, 16'h8000, 16'd32, 16'd1, 16'h4000, 1'b0, 1'b0);
      pkt(3'b001, 16'd0, 16'h8000, 16'h4000, 16'h8000, 16'h0C, 16'd1, 16'h4000, 1'b1, 1'b0);
      pkt(3'b100, 16'd0, 16'h8000, 16'h4000, 16'h8000, 16'd21, 16'd1, 16'h4000, 1'b1, 1'b0);
      pkt(3'b100, 16'd0, 16'h8000, 16'h4000, 16'h8000, 16'h0C, 16'd1, 16'h4000, 1'b1, 1'b0);
      pkt(3'b011, 16'd9, 16'h8000, 16'h4000, 16'h3000, 16'h0C, 16'd1, 16'h4000, 1'b1, 1'b1);
      idle();
      pkt(3'b101, 16'd3, 16'h8000, 16'h4000, 16'h8000, 16'd14, 16'd1, 16'h4000, 1'b1, 1'b0);
      pkt(3'b000, 16'd2, 16'h8000, 16'h4000, 16'h6000, 16'd0,  16'd2, 16'h2000, 1'b0, 1'b0);
      pkt(3'b101, 16'd0, 16'h8000, 16'h4000, 16'h8000, 16'd0,  16'd2, 16'h2000, 1'b0, 1'b0);
      pkt(3'b000, 16'd4, 16'h8000, 16'h4000, 16'h3000, 16'd0,  16'd4, 16'h0000, 1'b0, 1'b1);
      pkt(3'b101, 16'd0, 16'h8000, 16'h4000, 16'h8000, 16'd0,  16'd4, 16'h0000, 1'b0, 1'b0);
      pkt(3'b000, 16'd5, 16'h4000, 16'h4000, 16'h5000, 16'd0,  16'd5, 16'h4000, 1'b0, 1'b0);
      pkt(3'b101, 16'd0, 16'h8000, 16'h4000, 16'h8000, 16'd0,  16'd5, 16'h4000, 1'b0, 1'b0);
      pkt(3'b000, 16'd6, 16'h8000, 16'h4000, 16'h4000, 16'd0,  16'd6, 16'h0000, 1'b0, 1'b0);
      pkt(3'b101, 16'd0, 16'h8000, 16'h4000, 16'h8000, 16'd0,  16'd6, 16'h0000, 1'b0, 1'b0);
      pkt(3'b000, 16'd8, 16'h7000, 16'h1000, 16'h3000, 16'd0,  16'd8, 16'h1555, 1'b0, 1'b1);
      pkt(3'b000, 16'd6, 16'h8000, 16'h4000, 16'h3333, 16'd0,  16'd8, 16'h1555, 1'b0, 1'b1);
      pkt(3'b001, 16'd0, 16'h8000, 16'h4000, 16'h8000, 16'h0C, 16'd8, 16'h1555, 1'b1, 1'b0);
      pkt(3'b101, 16'd0, 16'h8000, 16'h4000, 16'h8000, 16'd0,  16'd8, 16'h1555, 1'b1, 1'b0);
      pkt(3'b000, 16'd9, 16'h8000, 16'h4000, 16'h8000, 16'd0,  16'd9, 16'h4000, 1'b0, 1'b0);
      idle();

      // Reset on the same edge as an HB strobe wins and clears the lock.
      @(negedge clk);
      nrst = 1'b0; en_MNI = 1'b1; fPktType = 3'b000; hops = 16'd7; energy = 16'h8000;
      push(16'h0, 16'h0, 1'b0, 1'b0);
      @(negedge clk);
      nrst = 1'b1; en_MNI = 1'b0;
      pkt(3'b000, 16'd7, 16'h8000, 16'h4000, 16'h8000, 16'd0,  16'd7, 16'h4000, 1'b0, 1'b0);
      idle();
      repeat (3) @(negedge clk);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/my_node_info.md
# my_node_info

Per-node state register for the energy-efficient routing node. It latches routing and energy information from decoded packets: hop distance to sink, normalized-energy Q-value, cluster-head role and low-energy flag. It sits after the packet decoder, which supplies the packet type and fields and pulses `en_MNI` once per decoded packet. The outputs feed the routing/Q-learning logic.

## Interface
- `NODE_ID`, default 16'h000C: this node's fixed identifier.
- `clk` input 1: clock, rising edge.
- `nrst` input 1: synchronous, active-low reset.
- `en_MNI` input 1: one-cycle strobe; the packet fields are valid while it is high.
- `fPktType` input 3: packet type. Encodings:
  - 000 heartbeat (HB)
  - 001 cluster-head election (CHE)
  - 010 invitation (INV)
  - 100 CH timeslot (CHT)
  - 101 data
  - all others are reserved.
- `e_max` input 16: network maximum energy, unsigned Q2.14.
- `e_min` input 16: network minimum energy, unsigned Q2.14.
- `energy` input 16: this node's residual energy, unsigned Q2.14.
- `destinationID` input 16: packet destination node ID.
- `hops` input 16: hop count carried in the packet.
- `timeslot` input 16: TDMA slot from a CHT packet.
- `e_threshold` input 16: low-energy threshold, unsigned Q2.14.
- `myNodeID` output 16: constant `NODE_ID`.
- `hopsFromSink` output 16: registered hop distance to sink.
- `myQValue` output 16: registered Q-value, unsigned Q2.14.
- `role` output 1: 1 = cluster head this round, 0 = member.
- `low_E` output 1: 1 when energy is at or below threshold.

## Operation
- Internal state: `HBLock` (1 bit).
- Packets are processed only on a cycle where `en_MNI`=1. With `en_MNI`=0 all state holds.
- **HB (000), `HBLock`=0 (accept):**
  - `hopsFromSink` <= `hops`.
  - `myQValue` <= Enorm.
  - `role` <= 0 (new round).
  - `HBLock` <= 1.
- **HB (000), `HBLock`=1:** the packet is dropped; no state changes except `low_E`.
- **Enorm computation:**
  - If `energy` <= `e_min`, Enorm = 0.
  - Else if `energy` >= `e_max` or `e_max` <= `e_min`, Enorm = 16'h4000 (1.0).
  - Else Enorm = ((`energy` − `e_min`) << 14) / (`e_max` − `e_min`). This is an unsigned 30-bit by 16-bit integer division, truncated; the result fits in 15 bits.
  - The divide is combinational.
- **CHE (001):**
  - If `destinationID` == `NODE_ID`, `role` <= 1.
  - Otherwise `role` is unchanged. A non-matching CHE never clears role.
- **INV (010):** no state change except `low_E`.
- **CHT (100):** no state change except `low_E`, whether or not `destinationID` matches and regardless of role. The `timeslot` port is reserved and unused.
- **Data (101):** `HBLock` <= 0. Other registers are unchanged.
- **Reserved types:** no state change except `low_E`.
- **`low_E`:** on every `en_MNI` cycle, regardless of type or lock, `low_E` <= (`energy` <= `e_threshold`), unsigned compare.
- **`myNodeID`:** tied to `NODE_ID` at all times, including during reset.

## Timing
- Reset occurs on a rising edge with `nrst`=0. Reset takes priority over `en_MNI`. After reset:
  - `hopsFromSink` = 0
  - `myQValue` = 0
  - `role` = 0
  - `low_E` = 0
  - `HBLock` = 0
- Latency is 1 cycle. Inputs sampled at the rising edge where `en_MNI`=1 appear on the outputs immediately after that edge.
- Back-to-back `en_MNI` pulses are legal. Each cycle is handled independently using the state from the previous cycle.
- No busy/ready handshake. The block accepts one packet every cycle.
- All arithmetic is unsigned. No result wraps: the Q-value saturates at 0 and 16'h4000.

## Test plan
1. **Reset:** hold `nrst`=0 for 5 cycles, then release. Expect all outputs 0 except `myNodeID`=16'h000C.
2. **First HB accepted:** type 000, `hops`=1, `e_max`=16'h8000, `e_min`=16'h4000, `energy`=16'h8000, `e_threshold`=16'h3333, one-cycle `en_MNI`. Expect `hopsFromSink`=1, `myQValue`=16'h4000, `low_E`=0.
3. **Second HB dropped:** type 000, `hops`=2, `energy`=16'h7FC0. Expect `hopsFromSink` to stay 1 and `myQValue` to stay 16'h4000. With `energy`=16'h3000 instead, expect `low_E`=1.
4. **Role selection:**
   - CHE with `destinationID`=32: expect `role`=0.
   - INV with `destinationID`=32: no change.
   - CHE with `destinationID`=16'h000C: expect `role`=1.
   - Then CHT packets with `destinationID`=21 and with 16'h000C: expect `role` stays 1 and `hopsFromSink` stays 1.
5. **Unlock:** a data packet (`destinationID`=14, `hops`=3) leaves all outputs unchanged. Then an HB with `hops`=2 and `energy`=16'h6000 is accepted: expect `hopsFromSink`=2, `myQValue`=16'h2000, `role`=0.
6. **Q-value edges:**
   - `energy`=16'h3000 < `e_min`: expect Q = 0.
   - `e_max`=`e_min`=16'h4000: expect Q = 16'h4000.
   - Reset asserted on the same edge as an `en_MNI` HB: expect all outputs 0.
